// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: runs a WIDTH-bit addition through one shared 1-bit
// full-adder cell, LSB first. Carry is taken from the cell and fed back, so
// this block never does arithmetic itself. All outputs are registered.
module serial_add_ctrl #(
   parameter int WIDTH     = 8,
   parameter int ADDER_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             add_a,
   output logic             add_b,
   output logic             add_cin,
   input  logic             add_s,
   input  logic             add_cout
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, FEED, WAIT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sh_a, sh_b;   // operand shift registers, bit 0 is on the cell
   logic [WIDTH-1:0] shadow;       // result assembled here, sum only sees it whole
   logic [CW-1:0]    cnt;

   // Sequencer: load on start, present one bit per FEED(/WAIT) pair, publish on last bit.
   // add_a/add_b/add_cin are loaded at the edge entering FEED and held through WAIT,
   // so the cell inputs stay stable for the whole bit slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         sh_a    <= '0;
         sh_b    <= '0;
         shadow  <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         add_a   <= 1'b0;
         add_b   <= 1'b0;
         add_cin <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               // DONE accepts start like IDLE, giving back-to-back operations
               if (start) begin
                  sh_a    <= op_a;
                  sh_b    <= op_b;
                  cnt     <= '0;
                  add_a   <= op_a[0];
                  add_b   <= op_b[0];
                  add_cin <= cin;
                  busy    <= 1'b1;
                  state   <= FEED;
               end else begin
                  state <= IDLE;
               end
            end
            FEED, WAIT: begin
               if (abort) begin
                  // drop the operation; sum/cout keep the last completed result
                  busy    <= 1'b0;
                  add_a   <= 1'b0;
                  add_b   <= 1'b0;
                  add_cin <= 1'b0;
                  state   <= IDLE;
               end else if (state == FEED && ADDER_LAT != 0) begin
                  // registered cell: give it one cycle before capturing
                  state <= WAIT;
               end else begin
                  shadow <= {add_s, shadow[WIDTH-1:1]};
                  if (cnt == CW'(WIDTH - 1)) begin
                     sum     <= {add_s, shadow[WIDTH-1:1]};
                     cout    <= add_cout;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     add_a   <= 1'b0;
                     add_b   <= 1'b0;
                     add_cin <= 1'b0;
                     state   <= DONE;
                  end else begin
                     cnt     <= cnt + CW'(1);
                     sh_a    <= sh_a >> 1;
                     sh_b    <= sh_b >> 1;
                     add_a   <= sh_a[1];
                     add_b   <= sh_b[1];
                     add_cin <= add_cout;
                     state   <= FEED;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: one instance per adder latency (0 and 1), each
// with its own behavioural adder cell. Stimulus pushes expected results into a
// scoreboard; a negedge monitor pops on done and also checks every bit slot.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]        start, abort, cin;
   logic [1:0][W-1:0] op_a, op_b;
   logic [1:0]        busy, done, cout, add_a, add_b, add_cin, add_s, add_cout;
   logic [1:0][W-1:0] sum;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      serial_add_ctrl #(.WIDTH(W), .ADDER_LAT(g)) u_dut (
         .clk(clk), .rst(rst), .start(start[g]), .abort(abort[g]),
         .op_a(op_a[g]), .op_b(op_b[g]), .cin(cin[g]),
         .busy(busy[g]), .done(done[g]), .sum(sum[g]), .cout(cout[g]),
         .add_a(add_a[g]), .add_b(add_b[g]), .add_cin(add_cin[g]),
         .add_s(add_s[g]), .add_cout(add_cout[g]));
      if (g == 0) begin : g_comb
         assign {add_cout[g], add_s[g]} = 2'(add_a[g]) + 2'(add_b[g]) + 2'(add_cin[g]);
      end else begin : g_reg
         always @(posedge clk or negedge rst)
            if (!rst) {add_cout[g], add_s[g]} <= 2'b00;
            else      {add_cout[g], add_s[g]} <= 2'(add_a[g]) + 2'(add_b[g]) + 2'(add_cin[g]);
      end
   end

   typedef struct {
      int         k;
      logic [W-1:0] s;
      logic       c;
      int         cyc;
   } exp_t;

   exp_t sbq[$];
   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   // operation currently expected on each instance's adder port
   logic [1:0][W-1:0] cur_a, cur_b;
   logic [1:0]        cur_c;
   int                st_cyc [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s lat=%0d: got %0h expected %0h (cyc %0d)", name, k, act, exp, cyc);
      end
   endtask

   // monitor
   int         mj, mi;
   logic [W:0] mpart, mmask;
   exp_t       me;
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         for (int k = 0; k < 2; k++) begin
            if (busy[k]) begin
               mj = cyc - st_cyc[k];
               mi = mj / (k + 1);
               if (mi < W) begin
                  mmask = (W+1)'((1 << mi) - 1);
                  mpart = (({1'b0, cur_a[k]} & mmask) + ({1'b0, cur_b[k]} & mmask)
                           + (W+1)'(cur_c[k])) >> mi;
                  chk("add_a_bit", k, 32'(add_a[k]), 32'(cur_a[k][mi]));
                  chk("add_b_bit", k, 32'(add_b[k]), 32'(cur_b[k][mi]));
                  chk("add_cin_bit", k, 32'(add_cin[k]), 32'(mpart[0]));
               end else begin
                  chk("busy_len", k, 32'(mj), 32'(W * (k + 1) - 1));
               end
            end else begin
               chk("add_idle", k, {29'd0, add_a[k], add_b[k], add_cin[k]}, 32'd0);
            end
            if (done[k]) begin
               if (sbq.size() == 0 || sbq[0].k != k) begin
                  chk("spurious_done", k, 32'd1, 32'd0);
               end else begin
                  me = sbq.pop_front();
                  chk("sum", k, 32'(sum[k]), 32'(me.s));
                  chk("cout", k, 32'(cout[k]), 32'(me.c));
                  chk("latency", k, 32'(cyc), 32'(me.cyc));
                  chk("busy_at_done", k, 32'(busy[k]), 32'd0);
               end
            end
         end
      end
   end

   // drive one start pulse; called at negedge+1. exp=0 for a start that must be ignored.
   task automatic issue(int k, logic [W-1:0] a, logic [W-1:0] b, logic c, bit exp);
      logic [W:0] tot;
      exp_t       e;
      start[k] = 1'b1;
      op_a[k]  = a;
      op_b[k]  = b;
      cin[k]   = c;
      if (exp) begin
         tot   = {1'b0, a} + {1'b0, b} + (W+1)'(c);
         e.k   = k;
         e.s   = tot[W-1:0];
         e.c   = tot[W];
         e.cyc = cyc + 1 + W * (1 + k);
         sbq.push_back(e);
         cur_a[k]  = a;
         cur_b[k]  = b;
         cur_c[k]  = c;
         st_cyc[k] = cyc + 1;
      end
      @(negedge clk); #1;
      start[k] = 1'b0;
      op_a[k]  = W'($urandom);
      op_b[k]  = W'($urandom);
      cin[k]   = 1'($urandom);
   endtask

   // wait until done is seen, leave at negedge+1 of the DONE cycle
   task automatic wait_done(int k);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done[k] && n < 100);
      if (!done[k]) chk("done_timeout", k, 32'd0, 32'd1);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   logic [W-1:0] ra, rb;
   logic         rc;

   initial begin
      start = '0; abort = '0; cin = '0; op_a = '0; op_b = '0;
      cur_a = '0; cur_b = '0; cur_c = '0;
      st_cyc[0] = 0; st_cyc[1] = 0;
      #1 rst = 1'b0;
      idle(2);
      for (int k = 0; k < 2; k++) begin
         chk("rst_busy", k, 32'(busy[k]), 32'd0);
         chk("rst_done", k, 32'(done[k]), 32'd0);
         chk("rst_sum", k, 32'(sum[k]), 32'd0);
         chk("rst_cout", k, 32'(cout[k]), 32'd0);
      end
      rst = 1'b1;
      idle(2);

      for (int k = 0; k < 2; k++) begin
         // directed basics
         issue(k, 8'h5A, 8'h33, 1'b0, 1'b1); wait_done(k); idle(2);
         issue(k, 8'hFF, 8'h01, 1'b0, 1'b1); wait_done(k); idle(2);
         // back-to-back: second start lands in the DONE cycle
         issue(k, 8'hFF, 8'hFF, 1'b1, 1'b1); wait_done(k);
         issue(k, 8'h01, 8'h02, 1'b0, 1'b1); wait_done(k); idle(2);
         // start while busy is ignored
         issue(k, 8'h0F, 8'h01, 1'b0, 1'b1); idle(3);
         issue(k, 8'h10, 8'h10, 1'b0, 1'b0);
         wait_done(k); idle(3);
         // abort at the 4th busy cycle
         issue(k, 8'h22, 8'h11, 1'b0, 1'b1); wait_done(k); idle(2);
         issue(k, 8'h80, 8'h80, 1'b0, 1'b1);
         idle(3);
         abort[k] = 1'b1;
         idle(1);
         abort[k] = 1'b0;
         void'(sbq.pop_back());
         chk("abort_busy", k, 32'(busy[k]), 32'd0);
         chk("abort_sum", k, 32'(sum[k]), 32'h33);
         chk("abort_cout", k, 32'(cout[k]), 32'd0);
         idle(25);
         // abort while idle with a start in the same cycle: start wins
         abort[k] = 1'b1;
         issue(k, 8'h44, 8'h0C, 1'b1, 1'b1);
         abort[k] = 1'b0;
         wait_done(k); idle(2);
         // randomized, some back-to-back
         for (int r = 0; r < 10; r++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            issue(k, ra, rb, rc, 1'b1);
            wait_done(k);
            if ($urandom_range(1) == 0) idle(1 + $urandom_range(2));
         end
         idle(3);
      end

      // asynchronous reset in the middle of an operation
      issue(1, 8'h80, 8'h17, 1'b0, 1'b1);
      idle(3);
      #2 rst = 1'b0;
      #1;
      sbq.delete();
      for (int k = 0; k < 2; k++) begin
         chk("arst_busy", k, 32'(busy[k]), 32'd0);
         chk("arst_sum", k, 32'(sum[k]), 32'd0);
         chk("arst_add", k, {29'd0, add_a[k], add_b[k], add_cin[k]}, 32'd0);
      end
      idle(2);
      rst = 1'b1;
      idle(1);
      issue(1, 8'h01, 8'h01, 1'b0, 1'b1); wait_done(1); idle(2);
      issue(0, 8'h01, 8'h01, 1'b0, 1'b1); wait_done(0); idle(2);

      chk("sb_empty", 0, 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit additions on the team's clocked 1-bit full adder (the `adder` cell), bit-serially and LSB first. It latches two operands and a carry-in on start. Each bit is fed to the adder and the sum bit is captured; the adder's carry-out is fed back as the next carry-in. When all bits are done, the controller presents the full sum and final carry. It sits between the counter/numerator logic and the single shared adder cell.

Parameters:
WIDTH, 8, operand/sum width in bits (>=2)
ADDER_LAT, 1, adder output latency in cycles: 0 = combinational, 1 = registered

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  request new addition; sampled only in IDLE or DONE
abort  in  1  synchronous abort of the operation in progress
op_a  in  WIDTH  operand A, latched on accepted start
op_b  in  WIDTH  operand B, latched on accepted start
cin  in  1  initial carry, latched on accepted start
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse when sum/cout become valid
sum  out  WIDTH  result, held until next accepted start completes
cout  out  1  final carry, held with sum
add_a  out  1  bit A to adder (bit_A)
add_b  out  1  bit B to adder (bit_B)
add_cin  out  1  carry to adder (in_c)
add_s  in  1  adder sum (out_s)
add_cout  in  1  adder carry (out_c)

Behaviour:
- Reset (rst=0, async): state IDLE; busy, done, sum, cout, add_a, add_b, add_cin all 0; bit counter 0. All outputs are registered.
- States: IDLE, FEED, WAIT (exists only if ADDER_LAT=1), DONE.
- IDLE: start=1 at edge t0:
  - latch op_a/op_b into shift registers and cin into the carry register;
  - counter=0; next state FEED; busy=1 from t0+1.
- FEED: add_a/add_b = current LSBs; add_cin = carry register.
  - If ADDER_LAT=0: in the same cycle, capture add_s into sum[counter] and add_cout into the carry register, then shift operands and increment counter.
  - If ADDER_LAT=1: go to WAIT; add_* inputs stay stable.
- WAIT (ADDER_LAT=1 only): capture add_s and add_cout as above, shift, increment, return to FEED.
- After bit WIDTH-1 is captured:
  - next state DONE; busy=0; done=1 for exactly one cycle;
  - cout = final carry; sum fully updated.
- Latency from start edge to done high: WIDTH*(1+ADDER_LAT)+1 cycles. This is 9 for WIDTH=8/LAT=0 and 17 for WIDTH=8/LAT=1.
- sum is built in a shadow register and copied to the sum output on entry to DONE. The sum output never shows partial results.
- DONE: lasts one cycle, then goes to IDLE. start=1 during DONE is accepted exactly as in IDLE (back-to-back operations with no idle gap).
- start while busy: ignored; operands are not re-latched.
- abort=1 in FEED/WAIT: go to IDLE next cycle; busy=0; no done pulse; sum/cout keep their previous values; add_* driven 0.
  - abort and start in the same IDLE cycle: start wins.
  - abort during DONE: no effect.
- add_a/add_b/add_cin are driven 0 in IDLE and DONE.
- Carry chain uses the adder's carry only. The controller performs no arithmetic itself.
- Reset asserted mid-operation: immediate return to reset values; operation lost; no done pulse.

Test Plan:
- WIDTH=8, LAT=0: op_a=0x5A, op_b=0x33, cin=0, start 1 cycle -> busy high for 8 cycles; done at t0+9; sum=0x8D; cout=0.
- WIDTH=8, LAT=1: op_a=0xFF, op_b=0x01, cin=0 -> done at t0+17; sum=0x00; cout=1; add_a/add_b/add_cin stable across each FEED/WAIT pair.
- op_a=0xFF, op_b=0xFF, cin=1 -> sum=0xFF, cout=1. Then start asserted during the DONE cycle with 0x01+0x02, cin=0 -> second done with sum=0x03, cout=0, no idle cycle between operations.
- Start pulse with 0x10+0x10 while busy, mid-operation of 0x0F+0x01 -> ignored; result sum=0x10, cout=0; exactly one done pulse.
- After a completed 0x22+0x11 (sum=0x33), start 0x80+0x80, then abort at the 4th busy cycle -> busy=0 next cycle; no done; sum stays 0x33, cout stays 0.
- Drive rst=0 asynchronously between clock edges mid-operation -> all outputs 0 immediately. After release, start 0x01+0x01 -> sum=0x02 at the expected latency.
